// File: rtl/bram_responder.sv
// bram_responder: memory side of a native BRAM port.
// Holds a C_DEPTH-word array with byte-lane writes and a registered read
// that returns the old contents when a read and a write hit the same word.
// The array is zero-filled after reset (when C_CLEAR_ON_RESET) and on
// clear_req. Out-of-range, busy-time and read/write collision accesses are
// reported on sticky error flags.
// Optional feature macro: BRAM_RESPONDER_STATS_EN adds saturating
// read/write counters (rd_count, wr_count) and their clear input stats_clr.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | zero-filling one word per cycle, accesses ignored, busy=1
// S_READY | serving reads and writes, busy=0
module bram_responder #(
    parameter int C_ADDR_WIDTH     = 12,
    parameter int C_DATA_WIDTH     = 64,
    parameter int C_DEPTH          = 4096,
    parameter int C_CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bram_clk,
    input  logic [C_ADDR_WIDTH-1:0]   bram_addr,
    input  logic                      bram_en,
    input  logic [C_DATA_WIDTH/8-1:0] bram_we,
    input  logic [C_DATA_WIDTH-1:0]   bram_din,
    output logic [C_DATA_WIDTH-1:0]   bram_dout,
    input  logic                      clear_req,
    input  logic                      err_clr,
    output logic                      busy,
    output logic                      err_range,
    output logic                      err_busy,
`ifdef BRAM_RESPONDER_STATS_EN
    input  logic                      stats_clr,
    output logic [31:0]               rd_count,
    output logic [31:0]               wr_count,
`endif
    output logic                      err_collide
);

    localparam int LANES = C_DATA_WIDTH / 8;
    // Index width of the storage array; at least one bit so C_DEPTH=1 works.
    localparam int IDX_W = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    // One spare bit so the fill index never wraps at C_DEPTH = 2^C_ADDR_WIDTH.
    localparam int CLR_W = $clog2(C_DEPTH) + 1;
    localparam logic [C_ADDR_WIDTH:0] DEPTH_A  = (C_ADDR_WIDTH + 1)'(C_DEPTH);
    localparam logic [CLR_W-1:0]      LAST_IDX = CLR_W'(C_DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                  state;
    logic [CLR_W-1:0]        clr_idx;
    logic [C_DATA_WIDTH-1:0] mem [0:(1 << IDX_W) - 1];

    logic                    unused_bram_clk;
    logic                    access;
    logic                    in_range;
    logic [IDX_W-1:0]        a_idx;
    logic [IDX_W-1:0]        wr_idx;
    logic [C_DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]        wr_lanes;

    // bram_clk is by contract the same net as clk; it is only accepted.
    assign unused_bram_clk = bram_clk;

    assign access   = bram_en | (|bram_we);
    assign in_range = ({1'b0, bram_addr} < DEPTH_A);
    assign a_idx    = bram_addr[IDX_W-1:0];

    // Single write port: the fill engine owns it in S_CLEAR, the master in S_READY.
    always_comb begin
        wr_idx   = a_idx;
        wr_data  = bram_din;
        wr_lanes = '0;
        if (!reset) begin
            if (state == S_CLEAR) begin
                wr_idx   = clr_idx[IDX_W-1:0];
                wr_data  = '0;
                wr_lanes = '1;
            end else if (in_range) begin
                wr_lanes = bram_we;
            end
        end
    end

    // Byte-lane write into the array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lanes[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Registered read; non-blocking semantics give read-first on collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            bram_dout <= '0;
        end else if (state == S_READY && bram_en) begin
            bram_dout <= in_range ? mem[a_idx] : '0;
        end
    end

    // Fill sequencer and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= (C_CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            clr_idx <= '0;
            busy    <= (C_CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state <= S_READY;
                        busy  <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + CLR_W'(1);
                    end
                end
                default: begin
                    if (clear_req) begin
                        state   <= S_CLEAR;
                        clr_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Sticky error flags; a new detection beats err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_range   <= 1'b0;
            err_busy    <= 1'b0;
            err_collide <= 1'b0;
        end else begin
            err_range   <= (access && !in_range) | (err_range & ~err_clr);
            err_busy    <= (access && state == S_CLEAR) | (err_busy & ~err_clr);
            err_collide <= (bram_en && (|bram_we)) | (err_collide & ~err_clr);
        end
    end

`ifdef BRAM_RESPONDER_STATS_EN
    // Saturating counts of accepted in-range reads and writes.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == S_READY && in_range) begin
            if (bram_en && rd_count != 32'hFFFF_FFFF) begin
                rd_count <= rd_count + 32'd1;
            end
            if ((|bram_we) && wr_count != 32'hFFFF_FFFF) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_responder.sv
// Testbench for bram_responder (C_DEPTH=16, 5-bit addresses so that
// out-of-range addresses are reachable). A behavioural memory model is
// stepped once per clock and compared against the DUT on every falling
// edge; directed checks with literal values pin the model.
module tb_bram_responder;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int LANES = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [LANES-1:0] bram_we;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          clear_req;
    logic          err_clr;
    logic          stats_clr;
    logic          busy;
    logic          err_range;
    logic          err_busy;
    logic          err_collide;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    bram_responder #(
        .C_ADDR_WIDTH    (AW),
        .C_DATA_WIDTH    (DW),
        .C_DEPTH         (DEPTH),
        .C_CLEAR_ON_RESET(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bram_clk   (clk),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout),
        .clear_req  (clear_req),
        .err_clr    (err_clr),
        .busy       (busy),
        .err_range  (err_range),
        .err_busy   (err_busy),
`ifdef BRAM_RESPONDER_STATS_EN
        .stats_clr  (stats_clr),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
`endif
        .err_collide(err_collide)
    );

`ifndef BRAM_RESPONDER_STATS_EN
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Behavioural model state
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_dout;
    bit            m_er, m_eb, m_ec;
    int            m_fill;      // words still to be zeroed; >0 means busy
    longint        m_rd, m_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs sampled at that edge.
    task automatic model_step();
        bit acc, inr, set_r, set_b, set_c;
        int a;
        acc = bram_en || (bram_we != 0);
        inr = (int'(bram_addr) < DEPTH);
        a   = int'(bram_addr) % DEPTH;
        if (reset) begin
            m_dout = '0;
            m_er = 0; m_eb = 0; m_ec = 0;
            m_fill = DEPTH;
            m_rd = 0; m_wr = 0;
            return;
        end
        set_r = acc && !inr;
        set_c = bram_en && (bram_we != 0);
        set_b = 0;
        if (m_fill > 0) begin
            m_mem[DEPTH - m_fill] = '0;
            m_fill--;
            set_b = acc;
        end else begin
            if (bram_en) m_dout = inr ? m_mem[a] : '0;
            if (inr) begin
                for (int i = 0; i < LANES; i++)
                    if (bram_we[i]) m_mem[a][8*i +: 8] = bram_din[8*i +: 8];
                if (bram_en && m_rd < 64'hFFFF_FFFF) m_rd++;
                if (bram_we != 0 && m_wr < 64'hFFFF_FFFF) m_wr++;
            end
            if (clear_req) m_fill = DEPTH;
        end
        if (stats_clr) begin
            m_rd = 0;
            m_wr = 0;
        end
        m_er = set_r || (m_er && !err_clr);
        m_eb = set_b || (m_eb && !err_clr);
        m_ec = set_c || (m_ec && !err_clr);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bram_addr = '0; bram_en = 0; bram_we = '0; bram_din = '0;
        clear_req = 0; err_clr = 0; stats_clr = 0;
    endtask

    task automatic rd(input int addr);
        idle();
        bram_addr = AW'(addr); bram_en = 1;
        cyc();
    endtask

    task automatic wr(input int addr, input logic [63:0] d, input logic [7:0] we);
        idle();
        bram_addr = AW'(addr); bram_we = we; bram_din = d;
        cyc();
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dout", bram_dout, m_dout);
            check("busy", busy, m_fill > 0);
            check("err_range", err_range, m_er);
            check("err_busy", err_busy, m_eb);
            check("err_collide", err_collide, m_ec);
`ifdef BRAM_RESPONDER_STATS_EN
            check("rd_count", rd_count, m_rd[31:0]);
            check("wr_count", wr_count, m_wr[31:0]);
`endif
        end
    end

    initial begin
        int cnt;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_dout = '0; m_fill = 0; m_rd = 0; m_wr = 0;
        idle();
        reset = 1;
        cyc();
        cyc();
        chk_en = 1;
        check("rst_dout", bram_dout, 64'h0);
        check("rst_busy", busy, 1'b1);
        check("rst_errs", {err_range, err_busy, err_collide}, 3'b000);
        reset = 0;

        // Fill after reset lasts exactly DEPTH cycles.
        cnt = 0;
        while (busy && cnt < 40) begin
            cyc();
            cnt++;
        end
        check("busy_cycles", cnt, 16);

        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            check("zero_read", bram_dout, 64'h0);
        end

        // Byte-lane merge.
        wr(3, 64'h0123456789ABCDEF, 8'hFF);
        wr(3, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        rd(3);
        check("lane_merge", bram_dout, 64'h01234567FFFFFFFF);

        // Back-to-back reads.
        wr(0, 64'hA, 8'hFF);
        wr(1, 64'hB, 8'hFF);
        wr(2, 64'hC, 8'hFF);
        rd(0); check("b2b_0", bram_dout, 64'hA);
        rd(1); check("b2b_1", bram_dout, 64'hB);
        rd(2); check("b2b_2", bram_dout, 64'hC);

        // Read-first collision.
        wr(3, 64'h11, 8'hFF);
        check("no_collide_yet", err_collide, 1'b0);
        idle();
        bram_addr = 3; bram_en = 1; bram_we = 8'hFF; bram_din = 64'h22;
        cyc();
        check("collide_dout", bram_dout, 64'h11);
        check("collide_flag", err_collide, 1'b1);
        rd(3);
        check("collide_after", bram_dout, 64'h22);

        // Out-of-range write and read.
        wr(20, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        check("range_flag", err_range, 1'b1);
        rd(20);
        check("range_read", bram_dout, 64'h0);
        rd(4);
        check("range_no_alias", bram_dout, 64'h0);
        idle();
        err_clr = 1;
        cyc();
        check("err_clr_range", err_range, 1'b0);
        check("err_clr_collide", err_collide, 1'b0);

        // Write during fill is ignored.
        idle();
        clear_req = 1;
        cyc();
        check("clear_busy", busy, 1'b1);
        wr(5, 64'h5555, 8'hFF);
        check("busy_flag", err_busy, 1'b1);
`ifdef BRAM_RESPONDER_STATS_EN
        check("busy_wr_count", wr_count, 32'd7);
        check("busy_rd_count", rd_count, 32'd23);
`endif
        idle();
        cnt = 0;
        while (busy && cnt < 40) begin
            cyc();
            cnt++;
        end
        check("fill_done", busy, 1'b0);
        rd(5); check("cleared_5", bram_dout, 64'h0);
        rd(3); check("cleared_3", bram_dout, 64'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            bram_addr = AW'($urandom_range(0, 31));
            bram_en   = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) < 4) bram_we = LANES'($urandom);
            bram_din  = {$urandom, $urandom};
            clear_req = ($urandom_range(0, 99) == 0);
            err_clr   = ($urandom_range(0, 29) == 0);
            stats_clr = ($urandom_range(0, 199) == 0);
            reset     = ($urandom_range(0, 399) == 0);
            cyc();
            reset = 0;
        end

        idle();
        cyc();
        cyc();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
